// File: rtl/gate_bit_packer_if.sv
// ============================================================================
//  Module      : gate_bit_packer_if
//  Description : Bus bundle for gate_bit_packer. Carries the single-bit input
//                handshake (in_valid/in_ready/in_bit/flush) and the packed-word
//                output handshake (out_valid/out_ready/out_data/out_len) plus
//                the emitted-word counter.
//  Modports    : master - the environment side (drives in_*, flush, out_ready)
//                slave  - the packer side (drives in_ready, out_*, word_cnt)
//  Options     : GATE_BIT_PACKER_PARITY_EN adds out_parity to the bundle.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface gate_bit_packer_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic             in_bit;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [5:0]       out_len;
    logic [7:0]       word_cnt;
`ifdef GATE_BIT_PACKER_PARITY_EN
    logic             out_parity;
`endif

    modport master (
        output in_valid,
        output in_bit,
        output flush,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_len,
        input  word_cnt
`ifdef GATE_BIT_PACKER_PARITY_EN
        , input out_parity
`endif
    );

    modport slave (
        input  in_valid,
        input  in_bit,
        input  flush,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_len,
        output word_cnt
`ifdef GATE_BIT_PACKER_PARITY_EN
        , output out_parity
`endif
    );
endinterface

`default_nettype wire

// File: rtl/gate_bit_packer.sv
// ============================================================================
//  Module      : gate_bit_packer
//  Description : Collects one result bit per accepted transfer from the gate
//                stage, packs the bits LSB-first into a WIDTH-bit word and
//                presents the word on a valid/ready port. A flush closes a
//                partial word early. word_cnt counts handed-off words (mod 256).
//  Ports       : clk      - rising-edge clock
//                reset_n  - asynchronous active-low reset
//                bus      - gate_bit_packer_if.slave:
//                           in_valid/in_ready/in_bit : bit input handshake
//                           flush                    : close partial word
//                           out_valid/out_ready      : word output handshake
//                           out_data[WIDTH-1:0]      : packed word, bit 0 first
//                           out_len[5:0]             : valid bits in out_data
//                           word_cnt[7:0]            : words handed off
//                           out_parity               : XOR of word bits
//                                                      (parity build only)
//  Parameters  : WIDTH - packed word width, 2..32
//  Options     : GATE_BIT_PACKER_PARITY_EN enables the out_parity register.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gate_bit_packer #(
    parameter int WIDTH = 8
) (
    input  wire logic        clk,
    input  wire logic        reset_n,
    gate_bit_packer_if.slave bus
);

    typedef enum logic [0:0] {
        S_FILL = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    localparam logic [5:0] c_full_len = 6'(WIDTH);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [5:0]       r_count;
    logic [5:0]       w_count_nxt;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] w_data_nxt;
    logic [5:0]       r_len;
    logic [5:0]       w_len_nxt;
    logic [7:0]       r_word_cnt;
    logic [7:0]       w_word_cnt_nxt;

    logic             w_accept;
    logic             w_handshake;
    logic [5:0]       w_count_acc;

    // Acceptance depends on state only, so in_ready has no combinational
    // path from any input.
    assign w_accept    = (r_state == S_FILL) && bus.in_valid;
    assign w_handshake = (r_state == S_HOLD) && bus.out_ready;
    // Fill level including a bit accepted this cycle; a same-cycle flush
    // sees this value, so a flush alongside the completing bit yields one
    // full word and nothing extra.
    assign w_count_acc = r_count + 6'(w_accept);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath next values
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_count_nxt    = r_count;
        w_data_nxt     = r_data;
        w_len_nxt      = r_len;
        w_word_cnt_nxt = r_word_cnt;

        case (r_state)
            S_FILL: begin
                if (w_accept) begin
                    for (int i = 0; i < WIDTH; i++) begin
                        if (r_count == 6'(i)) begin
                            w_data_nxt[i] = bus.in_bit;
                        end
                    end
                end
                w_count_nxt = w_count_acc;
                if (w_count_acc == c_full_len) begin
                    w_state_nxt = S_HOLD;
                    w_len_nxt   = c_full_len;
                end else if (bus.flush && (w_count_acc != 6'd0)) begin
                    w_state_nxt = S_HOLD;
                    w_len_nxt   = w_count_acc;
                end
            end
            S_HOLD: begin
                // Flush and in_valid are ignored here; word is frozen.
                if (bus.out_ready) begin
                    w_state_nxt    = S_FILL;
                    w_count_nxt    = 6'd0;
                    w_data_nxt     = '0;
                    w_len_nxt      = 6'd0;
                    w_word_cnt_nxt = r_word_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nxt = S_FILL;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count    <= 6'd0;
            r_data     <= '0;
            r_len      <= 6'd0;
            r_word_cnt <= 8'd0;
        end else begin
            r_count    <= w_count_nxt;
            r_data     <= w_data_nxt;
            r_len      <= w_len_nxt;
            r_word_cnt <= w_word_cnt_nxt;
        end
    end

`ifdef GATE_BIT_PACKER_PARITY_EN
    logic r_parity;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_parity <= 1'b0;
        end else if (w_handshake) begin
            r_parity <= 1'b0;
        end else if (w_accept) begin
            r_parity <= r_parity ^ bus.in_bit;
        end
    end

    assign bus.out_parity = r_parity;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.in_ready  = (r_state == S_FILL);
    assign bus.out_valid = (r_state == S_HOLD);
    assign bus.out_data  = r_data;
    assign bus.out_len   = r_len;
    assign bus.word_cnt  = r_word_cnt;

    // Handshake is only consumed by the parity register.
    logic w_unused;
    assign w_unused = w_handshake;

endmodule

`default_nettype wire

// File: tb/tb_gate_bit_packer.sv
// ============================================================================
//  Module      : tb_gate_bit_packer
//  Description : Self-checking bench for gate_bit_packer (WIDTH = 8). A small
//                reference model pushes expected words into a scoreboard queue
//                as bits are driven; words are popped and compared when the
//                packer presents them.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gate_bit_packer;

    localparam int WIDTH = 8;

    typedef struct packed {
        logic [31:0] data;
        logic [5:0]  len;
        logic        par;
    } exp_t;

    logic clk;
    logic reset_n;

    gate_bit_packer_if #(.WIDTH(WIDTH)) bus ();

    gate_bit_packer #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;

    exp_t sb[$];
    logic [WIDTH-1:0] m_data;
    int   m_cnt;
    logic m_par;
    logic [7:0] m_words;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_push();
        exp_t e;
        e.data = 32'(m_data);
        e.len  = 6'(m_cnt);
        e.par  = m_par;
        sb.push_back(e);
        m_data = '0;
        m_cnt  = 0;
        m_par  = 1'b0;
    endtask

    task automatic model_accept(input logic b);
        m_data[m_cnt] = b;
        m_par = m_par ^ b;
        m_cnt++;
        if (m_cnt == WIDTH) model_push();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one bit (optionally with flush) once the packer is ready.
    task automatic send_bit(input logic b, input logic fl);
        for (int i = 0; i < 20 && !bus.in_ready; i++) tick();
        chk("in_ready_wait", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_bit   = b;
        bus.flush    = fl;
        tick();
        bus.in_valid = 1'b0;
        bus.in_bit   = 1'b0;
        bus.flush    = 1'b0;
        model_accept(b);
        if (fl && m_cnt > 0) model_push();
    endtask

    task automatic send_flush();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        if (m_cnt > 0) model_push();
    endtask

    // Wait for a word, compare against scoreboard, hold it for hold_cycles
    // (optionally pulsing flush), then complete the handshake.
    task automatic expect_word(input int hold_cycles, input logic flush_in_hold);
        exp_t e;
        for (int i = 0; i < 20 && !bus.out_valid; i++) tick();
        chk("out_valid_wait", 32'(bus.out_valid), 32'd1);
        chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) e = sb.pop_front();
        else e = '0;
        chk("out_data", 32'(bus.out_data), e.data);
        chk("out_len", 32'(bus.out_len), 32'(e.len));
        chk("in_ready_hold", 32'(bus.in_ready), 32'd0);
`ifdef GATE_BIT_PACKER_PARITY_EN
        chk("out_parity", 32'(bus.out_parity), 32'(e.par));
`endif
        for (int i = 0; i < hold_cycles; i++) begin
            bus.flush = flush_in_hold;
            tick();
            bus.flush = 1'b0;
            chk("hold_valid", 32'(bus.out_valid), 32'd1);
            chk("hold_data", 32'(bus.out_data), e.data);
            chk("hold_len", 32'(bus.out_len), 32'(e.len));
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        m_words = m_words + 8'd1;
        chk("post_hs_valid", 32'(bus.out_valid), 32'd0);
        chk("post_hs_ready", 32'(bus.in_ready), 32'd1);
        chk("post_hs_data", 32'(bus.out_data), 32'd0);
        chk("post_hs_len", 32'(bus.out_len), 32'd0);
        chk("word_cnt", 32'(bus.word_cnt), 32'(m_words));
`ifdef GATE_BIT_PACKER_PARITY_EN
        chk("post_hs_parity", 32'(bus.out_parity), 32'd0);
`endif
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_out_data"}, 32'(bus.out_data), 32'd0);
        chk({tag, "_out_len"}, 32'(bus.out_len), 32'd0);
        chk({tag, "_word_cnt"}, 32'(bus.word_cnt), 32'd0);
`ifdef GATE_BIT_PACKER_PARITY_EN
        chk({tag, "_parity"}, 32'(bus.out_parity), 32'd0);
`endif
    endtask

    initial begin
        logic [7:0] pattern;
        logic [7:0] start_cnt;
        int acc_cnt;
        int hs_cnt;
        logic acc;
        logic hs;
        logic b;
        exp_t e;

        m_data  = '0;
        m_cnt   = 0;
        m_par   = 1'b0;
        m_words = 8'd0;

        bus.in_valid  = 1'b0;
        bus.in_bit    = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        reset_n       = 1'b0;
        repeat (3) tick();
        check_reset_values("reset");
        reset_n = 1'b1;
        tick();

        // Full word 1,0,1,1,0,0,1,0 -> 8'h4D, held 3 cycles with flush pulses
        pattern = 8'b0100_1101;
        for (int i = 0; i < 8; i++) send_bit(pattern[i], 1'b0);
        chk("word0_data", 32'(bus.out_data), 32'h4D);
        expect_word(3, 1'b1);
        tick();
        chk("hold_flush_ignored", 32'(bus.out_valid), 32'd0);

        // Partial word via flush alone
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
        send_flush();
        chk("partial_data", 32'(bus.out_data), 32'h07);
        chk("partial_len", 32'(bus.out_len), 32'd3);
        expect_word(1, 1'b0);

        // Flush with nothing collected is ignored
        send_flush();
        chk("empty_flush_valid", 32'(bus.out_valid), 32'd0);
        chk("empty_flush_ready", 32'(bus.in_ready), 32'd1);
        chk("empty_flush_sb", 32'(sb.size()), 32'd0);

        // Completing bit together with flush -> one full word only
        pattern = 8'b1011_0110;
        for (int i = 0; i < 7; i++) send_bit(pattern[i], 1'b0);
        send_bit(pattern[7], 1'b1);
        chk("flush_full_len", 32'(bus.out_len), 32'd8);
        expect_word(1, 1'b0);
        tick();
        chk("no_trailing_word", 32'(bus.out_valid), 32'd0);

        // Streaming 256 words with out_ready held high
        start_cnt = bus.word_cnt;
        acc_cnt = 0;
        hs_cnt  = 0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 256 * 9; c++) begin
            b = 1'($urandom);
            bus.in_valid = 1'b1;
            bus.in_bit   = b;
            acc = bus.in_ready;
            hs  = bus.out_valid;
            if (hs) begin
                chk("stream_sb_nonempty", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) e = sb.pop_front();
                else e = '0;
                chk("stream_data", 32'(bus.out_data), e.data);
                chk("stream_len", 32'(bus.out_len), 32'(e.len));
`ifdef GATE_BIT_PACKER_PARITY_EN
                chk("stream_parity", 32'(bus.out_parity), 32'(e.par));
`endif
                hs_cnt++;
                m_words = m_words + 8'd1;
            end
            if (acc) begin
                model_accept(b);
                acc_cnt++;
            end
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        chk("stream_accepts", 32'(acc_cnt), 32'd2048);
        chk("stream_words", 32'(hs_cnt), 32'd256);
        chk("stream_wrap", 32'(bus.word_cnt), 32'(start_cnt));
        chk("stream_wrap_model", 32'(bus.word_cnt), 32'(m_words));

        // Reset in the middle of a word discards it
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
        reset_n = 1'b0;
        #1;
        check_reset_values("midword_reset");
        tick();
        reset_n = 1'b1;
        m_data  = '0;
        m_cnt   = 0;
        m_par   = 1'b0;
        m_words = 8'd0;
        sb.delete();
        tick();
        check_reset_values("after_reset");
        pattern = 8'b0000_0001;
        for (int i = 0; i < 8; i++) send_bit(pattern[i], 1'b0);
        chk("restart_data", 32'(bus.out_data), 32'h01);
        expect_word(0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/gate_bit_packer.md
# gate_bit_packer

Downstream consumer for the single-bit gate-operation stage (and/or/nand/nor selected by generate-case). Collects one result bit per accepted transfer, packs bits LSB-first into a WIDTH-bit word, and presents the word on a valid/ready output port. Supports early flush of a partial word and keeps a wrapping count of words emitted.

## Interface
- WIDTH, 8, packed word width; legal range 2..32.
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_bit is valid this cycle.
- in_ready  output  1  packer accepts a bit this cycle.
- in_bit  input  1  result bit from the gate stage (its output c).
- flush  input  1  close the current partial word; sampled every cycle.
- out_valid  output  1  out_data/out_len hold a completed word.
- out_ready  input  1  downstream accepts the word.
- out_data  output  WIDTH  packed word; first accepted bit in bit 0; unfilled bits 0.
- out_len  output  6  number of valid bits in out_data (1..WIDTH while out_valid).
- word_cnt  output  8  words handed off since reset; wraps 255 -> 0.
- out_parity  output  1  present only with GATE_BIT_PACKER_PARITY_EN (see Configuration).

## Operation
- Two states: FILL (collecting) and HOLD (word presented). Reset state FILL.
- in_ready = 1 in FILL, 0 in HOLD (combinational from state only).
- FILL, in_valid=1: bit written to out_data[count], count += 1.
  - Count reaches WIDTH: go to HOLD, out_len = WIDTH.
- FILL, flush=1 and count (after any same-cycle accept) in 1..WIDTH-1: go to HOLD, out_len = count, upper bits stay 0.
- flush with count 0 and no accept: ignored, stay FILL.
- flush on the same cycle as the bit that completes the word: full word, out_len = WIDTH; no extra word.
- flush in HOLD: ignored (not queued).
- HOLD: out_valid=1; out_data/out_len stable until handshake.
- HOLD, out_ready=1: handshake; next cycle FILL, count 0, out_data cleared to 0, out_len 0, word_cnt += 1 (mod 256).
- in_valid in HOLD: not accepted; upstream must hold the bit.
- out_ready in FILL: no effect.

## Timing
- Reset (async assert, sync effect on deassert): state FILL, count 0, out_valid 0, out_data 0, out_len 0, word_cnt 0, out_parity 0, in_ready 1.
- All outputs except in_ready are registered.
- Latency: out_valid rises the cycle after the edge that accepts bit WIDTH (or samples flush).
- HOLD lasts at least one cycle; in_ready returns 1 the cycle after the output handshake. Steady streaming with out_ready=1 gives WIDTH accepts per WIDTH+1 cycles.
- Reset mid-word or during HOLD discards the word; word_cnt not incremented.

## Configuration
- GATE_BIT_PACKER_PARITY_EN defined: out_parity port exists; it is a register holding the XOR of all accepted bits of the current word, updated with each accept, stable in HOLD, cleared to 0 on handshake and reset.
- Undefined: out_parity port and its logic absent; all other behaviour identical.

## Test plan
- WIDTH=8, reset, then bits 1,0,1,1,0,0,1,0 on consecutive cycles with out_ready=0 -> out_valid=1 next cycle, out_data=8'h4D, out_len=8, in_ready=0; parity (if enabled) = 0.
- Continue: hold out_ready=0 for 3 cycles, then 1 -> data stable throughout; after handshake word_cnt=1, in_ready=1, out_data=0.
- Bits 1,1,1 then flush alone -> out_data=8'h07, out_len=3; flush with count 0 -> no out_valid.
- 7 bits plus 8th bit with flush in same cycle -> one word, out_len=8, no trailing empty word.
- 256 words with out_ready=1 -> word_cnt wraps to 0; throughput 8 accepts per 9 cycles.
- Assert reset_n=0 after 5 bits, release -> all outputs at reset values, next word starts at bit 0, word_cnt unchanged from 0.
